cond_unit: RTL and testbench



---
 rtl/cond_unit.sv | 168 ++++++++++++++++
 tb/tb_cond_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
//==============================================================================
// Module   : cond_unit
// Brief    : Flags register plus branch-condition resolver for the t16q core.
//            Emits a one-deep registered redirect record {taken, pc} to fetch.
//            Optional statistics counters are built under COND_UNIT_STATS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cond_unit #(
    parameter int XLEN = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flags_we,
    input  logic [3:0]      flags_in,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [3:0]      br_cond,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] br_next,
    input  logic            flush,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic            redir_taken,
    output logic [XLEN-1:0] redir_pc,
    output logic [3:0]      flags_q,
    output logic [15:0]     stat_branches,
    output logic [15:0]     stat_taken
);

    localparam logic [15:0] c_stat_max = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_flags;
    logic [3:0]         w_flags_eff;
    logic               w_z;
    logic               w_c;
    logic               w_n;
    logic               w_v;
    logic               w_lt;
    logic [7:0]         w_base;
    logic               w_cond_true;
    logic               w_accept;
    logic               r_taken;
    logic [XLEN-1:0]    r_pc;

    //--------------------------------------------------------------------------
    // Flags register with same-cycle forwarding to the resolver
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (flags_we) begin
            r_flags <= flags_in;
        end
    end

    assign w_flags_eff            = flags_we ? flags_in : r_flags;
    assign {w_z, w_c, w_n, w_v}   = w_flags_eff;
    assign w_lt                   = w_n ^ w_v;

    // Condition codes come in complementary pairs: the odd code is the
    // inverse of the even one, so resolve the even predicate and flip on LSB.
    assign w_base = {
        ~w_z & ~w_lt,   // 14 GT  / 15 LE
        w_lt,           // 12 LT  / 13 GE
        ~w_c & ~w_z,    // 10 GTU / 11 LEU
        w_v,            //  8 VS  /  9 VC
        w_n,            //  6 MI  /  7 PL
        w_c,            //  4 LTU /  5 GEU
        w_z,            //  2 EQ  /  3 NE
        1'b1            //  0 AL  /  1 NV
    };

    assign w_cond_true = w_base[br_cond[3:1]] ^ br_cond[0];

    //--------------------------------------------------------------------------
    // Handshake and output-record state machine
    //--------------------------------------------------------------------------
    assign redir_valid = (r_state == ST_FULL);
    assign br_ready    = ~flush & (~redir_valid | redir_ready);
    assign w_accept    = br_valid & br_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!w_accept && redir_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // Flush wins over both consumption and acceptance.
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // The record is captured only at acceptance, so later flag writes or
    // stalls cannot disturb a resolved redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken <= 1'b0;
            r_pc    <= '0;
        end else if (w_accept) begin
            r_taken <= w_cond_true;
            r_pc    <= w_cond_true ? br_target : br_next;
        end
    end

    assign redir_taken = r_taken;
    assign redir_pc    = r_pc;
    assign flags_q     = r_flags;

    //--------------------------------------------------------------------------
    // Saturating statistics counters (cleared by reset only)
    //--------------------------------------------------------------------------
`ifdef COND_UNIT_STATS_EN
    logic [15:0] r_stat_branches;
    logic [15:0] r_stat_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches <= 16'h0000;
            r_stat_taken    <= 16'h0000;
        end else if (w_accept) begin
            if (r_stat_branches != c_stat_max) begin
                r_stat_branches <= r_stat_branches + 16'h0001;
            end
            if (w_cond_true && (r_stat_taken != c_stat_max)) begin
                r_stat_taken <= r_stat_taken + 16'h0001;
            end
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_taken    = r_stat_taken;
`else
    logic w_unused_stats;
    assign w_unused_stats = &c_stat_max;
    assign stat_branches  = 16'h0000;
    assign stat_taken     = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cond_unit.sv
//==============================================================================
// Module   : tb_cond_unit
// Brief    : Self-checking bench for cond_unit against a behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cond_unit;

    logic        clk;
    logic        rst_n;
    logic        flags_we;
    logic [3:0]  flags_in;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_cond;
    logic [15:0] br_target;
    logic [15:0] br_next;
    logic        flush;
    logic        redir_valid;
    logic        redir_ready;
    logic        redir_taken;
    logic [15:0] redir_pc;
    logic [3:0]  flags_q;
    logic [15:0] stat_branches;
    logic [15:0] stat_taken;

    int errors;
    int checks;

    // Behavioural model of the architectural state
    logic        m_valid;
    logic        m_taken;
    logic [15:0] m_pc;
    logic [3:0]  m_flags;
    logic [15:0] m_br;
    logic [15:0] m_tk;

    cond_unit #(.XLEN(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flags_we     (flags_we),
        .flags_in     (flags_in),
        .br_valid     (br_valid),
        .br_ready     (br_ready),
        .br_cond      (br_cond),
        .br_target    (br_target),
        .br_next      (br_next),
        .flush        (flush),
        .redir_valid  (redir_valid),
        .redir_ready  (redir_ready),
        .redir_taken  (redir_taken),
        .redir_pc     (redir_pc),
        .flags_q      (flags_q),
        .stat_branches(stat_branches),
        .stat_taken   (stat_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] f);
        bit z, c, n, v;
        z = f[3]; c = f[2]; n = f[1]; v = f[0];
        case (cc)
            4'd0:    return 1'b1;
            4'd1:    return 1'b0;
            4'd2:    return z;
            4'd3:    return !z;
            4'd4:    return c;
            4'd5:    return !c;
            4'd6:    return n;
            4'd7:    return !n;
            4'd8:    return v;
            4'd9:    return !v;
            4'd10:   return !c && !z;
            4'd11:   return c || z;
            4'd12:   return n != v;
            4'd13:   return n == v;
            4'd14:   return !z && (n == v);
            default: return z || (n != v);
        endcase
    endfunction

    function automatic bit model_ready();
        return !flush && (!m_valid || redir_ready);
    endfunction

    task automatic idle_inputs();
        flags_we = 0; flags_in = 0; br_valid = 0; br_cond = 0;
        br_target = 0; br_next = 0; flush = 0; redir_ready = 1;
    endtask

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        bit acc, t, fwe, fl, rr;
        logic [3:0]  fin, eff;
        logic [15:0] tgt, nxt;
        fwe = flags_we; fin = flags_in; fl = flush; rr = redir_ready;
        tgt = br_target; nxt = br_next;
        eff = fwe ? fin : m_flags;
        t   = ref_cond(br_cond, eff);
        acc = br_valid && model_ready();
        @(posedge clk);
        #1;
        if (fwe) m_flags = fin;
        if (fl) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_taken = t; m_pc = t ? tgt : nxt;
        end else if (rr) m_valid = 0;
`ifdef COND_UNIT_STATS_EN
        if (acc) begin
            if (m_br != 16'hFFFF) m_br = m_br + 1;
            if (t && m_tk != 16'hFFFF) m_tk = m_tk + 1;
        end
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        m_valid = 0; m_taken = 0; m_pc = 0; m_flags = 0; m_br = 0; m_tk = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({redir_valid, redir_taken, redir_pc, flags_q, stat_branches, stat_taken} !== 54'd0) begin
            errors++; $display("FAIL reset_outputs got v=%0b t=%0b pc=%h f=%b sb=%h st=%h exp all 0",
                redir_valid, redir_taken, redir_pc, flags_q, stat_branches, stat_taken);
        end
        checks++;
        if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_br_ready got=%0b exp=1", br_ready); end

        // Hold a taken record under stall, then reset between clock edges.
        flags_we = 1; flags_in = 4'b1111; br_valid = 1; br_cond = 4'd0;
        br_target = 16'hBEEF; br_next = 16'h0001; redir_ready = 0;
        tick();
        idle_inputs(); redir_ready = 0;
        tick();
        checks++;
        if ({redir_valid, redir_taken, redir_pc} !== {1'b1, 1'b1, 16'hBEEF}) begin
            errors++; $display("FAIL reset_pre_hold got v=%0b t=%0b pc=%h exp v=1 t=1 pc=beef",
                redir_valid, redir_taken, redir_pc);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({redir_valid, redir_taken, redir_pc, flags_q, stat_branches, stat_taken} !== 54'd0) begin
            errors++; $display("FAIL reset_async got v=%0b t=%0b pc=%h f=%b sb=%h st=%h exp all 0",
                redir_valid, redir_taken, redir_pc, flags_q, stat_branches, stat_taken);
        end
        do_reset();
        checks++;
        if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%0b exp=1", br_ready); end
    endtask

    task automatic test_forwarding();
        idle_inputs();
        flags_we = 1; flags_in = 4'b1000; br_valid = 1; br_cond = 4'd2;
        br_target = 16'h0040; br_next = 16'h0012;
        tick();
        idle_inputs(); redir_ready = 0;
        checks++;
        if ({redir_valid, redir_taken, redir_pc, flags_q} !== {1'b1, 1'b1, 16'h0040, 4'b1000}) begin
            errors++; $display("FAIL forwarding got v=%0b t=%0b pc=%h f=%b exp v=1 t=1 pc=0040 f=1000",
                redir_valid, redir_taken, redir_pc, flags_q);
        end
        redir_ready = 1;
        tick();
    endtask

    task automatic test_signed_unsigned();
        logic [3:0] conds [5];
        logic       exp_t [5];
        logic [15:0] exp_pc;
        conds = '{4'd4, 4'd12, 4'd13, 4'd10, 4'd14};
        exp_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        idle_inputs();
        flags_we = 1; flags_in = 4'b0110;
        tick();
        checks++;
        if (flags_q !== 4'b0110) begin errors++; $display("FAIL su_flags got=%b exp=0110", flags_q); end
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            br_valid = 1; br_cond = conds[i];
            br_target = 16'h0100 + 16'(i); br_next = 16'h0200 + 16'(i);
            exp_pc = exp_t[i] ? br_target : br_next;
            tick();
            checks++;
            if ({redir_valid, redir_taken, redir_pc} !== {1'b1, exp_t[i], exp_pc}) begin
                errors++; $display("FAIL su_cond%0d got v=%0b t=%0b pc=%h exp v=1 t=%0b pc=%h",
                    conds[i], redir_valid, redir_taken, redir_pc, exp_t[i], exp_pc);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        br_valid = 1; br_cond = 4'd0; br_target = 16'h1234; br_next = 16'h0002; redir_ready = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            flags_we = 1; flags_in = 4'b0000; br_valid = 1; br_cond = 4'd2;
            br_target = 16'h5555; br_next = 16'h0066; redir_ready = 0;
            #1;
            checks++;
            if (br_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got=%0b exp=0", i, br_ready); end
            tick();
            checks++;
            if ({redir_valid, redir_taken, redir_pc} !== {1'b1, 1'b1, 16'h1234}) begin
                errors++; $display("FAIL bp_hold%0d got v=%0b t=%0b pc=%h exp v=1 t=1 pc=1234",
                    i, redir_valid, redir_taken, redir_pc);
            end
        end
        flags_we = 0; redir_ready = 1;
        #1;
        checks++;
        if (br_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", br_ready); end
        tick();
        checks++;
        if ({redir_valid, redir_taken, redir_pc} !== {1'b1, 1'b0, 16'h0066}) begin
            errors++; $display("FAIL bp_replace got v=%0b t=%0b pc=%h exp v=1 t=0 pc=0066",
                redir_valid, redir_taken, redir_pc);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        logic [15:0] br_before;
        idle_inputs();
        br_valid = 1; br_cond = 4'd0; br_target = 16'h0A0A; redir_ready = 0;
        tick();
        br_before = m_br;
        br_cond = 4'd0; br_target = 16'h0B0B; flush = 1; redir_ready = 0;
        #1;
        checks++;
        if (br_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%0b exp=0", br_ready); end
        tick();
        idle_inputs();
        checks++;
        if (redir_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", redir_valid); end
        checks++;
        if (stat_branches !== br_before) begin
            errors++; $display("FAIL flush_stats got=%h exp=%h", stat_branches, br_before);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            flags_we    = ($urandom_range(0, 2) == 0);
            flags_in    = 4'($urandom);
            br_valid    = ($urandom_range(0, 9) < 7);
            br_cond     = 4'($urandom);
            br_target   = 16'($urandom);
            br_next     = 16'($urandom);
            flush       = ($urandom_range(0, 9) == 0);
            redir_ready = ($urandom_range(0, 9) < 6);
            #1;
            checks++;
            if (br_ready !== model_ready()) begin
                errors++; $display("FAIL rand_ready%0d got=%0b exp=%0b", i, br_ready, model_ready());
            end
            tick();
            checks++;
            if ({redir_valid, flags_q, stat_branches, stat_taken} !== {m_valid, m_flags, m_br, m_tk}) begin
                errors++; $display("FAIL rand_state%0d got v=%0b f=%b sb=%h st=%h exp v=%0b f=%b sb=%h st=%h",
                    i, redir_valid, flags_q, stat_branches, stat_taken, m_valid, m_flags, m_br, m_tk);
            end
            if (m_valid) begin
                checks++;
                if ({redir_taken, redir_pc} !== {m_taken, m_pc}) begin
                    errors++; $display("FAIL rand_record%0d got t=%0b pc=%h exp t=%0b pc=%h",
                        i, redir_taken, redir_pc, m_taken, m_pc);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_stats();
        do_reset();
        idle_inputs();
        br_valid = 1;
        for (int i = 0; i < 8; i++) begin
            br_cond = (i < 5) ? 4'd0 : 4'd1;
            tick();
        end
`ifdef COND_UNIT_STATS_EN
        checks++;
        if ({stat_branches, stat_taken} !== {16'd8, 16'd5}) begin
            errors++; $display("FAIL stats_nv got sb=%0d st=%0d exp sb=8 st=5", stat_branches, stat_taken);
        end
        br_cond = 4'd0;
        for (int i = 0; i < 70000; i++) tick();
        checks++;
        if ({stat_branches, stat_taken} !== {16'hFFFF, 16'hFFFF}) begin
            errors++; $display("FAIL stats_sat got sb=%h st=%h exp ffff ffff", stat_branches, stat_taken);
        end
`else
        checks++;
        if ({stat_branches, stat_taken} !== 32'd0) begin
            errors++; $display("FAIL stats_off got sb=%h st=%h exp 0 0", stat_branches, stat_taken);
        end
`endif
        idle_inputs();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 0;
        idle_inputs();
        test_reset();
        test_forwarding();
        test_signed_unsigned();
        test_back_to_back();
        test_flush();
        test_random();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
